axi4_lite_initiator: RTL
========================

Name: axi4_lite_initiator

Overview:
Synthesizable AXI4-lite master that turns a simple single-outstanding command/response interface into AXI4-lite read and write transactions. It is the initiator counterpart to the bench AXI memory responder. Its main use is to drive directed and self-checking traffic into the memory model, and the memory-mapped console/pass ports, without instantiating the CPU. It also has a watchdog that flags a hung responder.

Parameters:
TIMEOUT, 1024, cycles to wait for any single AXI handshake before aborting; 0 disables the watchdog.
TO_WIDTH, 16, width of the watchdog counter; must satisfy TIMEOUT < 2**TO_WIDTH.

Ports:
clk  input  1  system clock; all logic on the rising edge.
resetn  input  1  reset; asynchronous, active-low.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept a command.
cmd_write  input  1  1 = write, 0 = read.
cmd_insn  input  1  read is an instruction fetch; drives arprot[2].
cmd_addr  input  32  byte address.
cmd_wdata  input  32  write data.
cmd_wstrb  input  4  write byte strobes.
rsp_valid  output  1  response present.
rsp_ready  input  1  response consumed.
rsp_rdata  output  32  read data; 0 for writes and for timeouts.
rsp_timeout  output  1  response was produced by the watchdog.
halted  output  1  sticky; set by a timeout, cleared only by reset.
mem_axi_awvalid/awready/awaddr[31:0]/awprot[2:0]  out/in/out/out  AW channel.
mem_axi_wvalid/wready/wdata[31:0]/wstrb[3:0]  out/in/out/out  W channel.
mem_axi_bvalid/bready  in/out  B channel.
mem_axi_arvalid/arready/araddr[31:0]/arprot[2:0]  out/in/out/out  AR channel.
mem_axi_rvalid/rready/rdata[31:0]  in/out/in  R channel.

Behaviour:
- Reset values (asynchronous, on resetn=0): all AXI valids and readies 0, all AXI address/data/strb/prot fields 0, rsp_valid 0, rsp_rdata 0, rsp_timeout 0, halted 0, state IDLE.
- FSM states and transitions:
  - IDLE: cmd_ready = 1 only here and only when !halted. Command accepted on cmd_valid && cmd_ready. Address, data, strb and prot are registered at acceptance; all AXI outputs are registered.
  - Read, AR phase: arvalid = 1 from the cycle after acceptance, held until the arready handshake; araddr stays stable. arprot = {cmd_insn, 2'b00}.
  - Read, R phase: rready = 1. On rvalid: capture rdata and go to RESP.
  - Write, AW/W phase: awvalid and wvalid both rise the cycle after acceptance.
    - Each channel drops independently the cycle after its own handshake; internal aw_done and w_done flags record this.
    - The two handshakes may complete in either order or in the same cycle.
    - awprot = 3'b000.
    - When both flags are set, go to the B phase.
  - Write, B phase: bready = 1. On bvalid go to RESP; rsp_rdata = 0.
  - RESP: rsp_valid = 1 and held with stable data until rsp_ready, then return to IDLE.
- Latencies: minimum read, acceptance to rsp_valid, is 3 cycles with a zero-wait responder. A valid is never deasserted before its ready, except by the watchdog.
- Watchdog:
  - Counter clears on every state change and on every handshake; it increments while waiting in the AR, R, AW/W or B phase. RESP waiting is not counted.
  - When the counter reaches TIMEOUT: drop all AXI valids and readies, then go to RESP with rsp_timeout = 1 and rsp_rdata = 0. Set halted.
  - After that response is consumed, remain in IDLE with cmd_ready = 0 until reset. Dropping valid before ready is a deliberate AXI violation, acceptable only after a hang.
- Only one transaction is outstanding; no new command is accepted while rsp_valid = 1.
- Reset asserted mid-transaction: immediate return to reset values. No response is generated for the aborted command.

Test Plan:
- Zero-wait responder, memory[0x40] = 0xDEADBEEF, read 0x100 with cmd_insn=0 -> araddr=0x100, arprot=000, rsp_rdata=0xDEADBEEF, rsp_valid 3 cycles after acceptance.
- Write 0x200, wdata=0x12345678, wstrb=0011, with wready 2 cycles before awready -> wvalid drops first, awvalid held, single bready handshake, memory[0x80][15:0]=0x5678, upper bytes unchanged.
- Read with cmd_insn=1 -> arprot=3'b100; awready and wready in the same cycle on the following write -> both valids drop together, response correct.
- TIMEOUT=16, responder never asserts arready -> rsp_timeout=1 and rsp_rdata=0 after 16 waiting cycles, arvalid=0, halted=1, cmd_ready=0 afterwards despite cmd_valid=1.
- rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0 throughout; watchdog does not fire.
- resetn pulsed low while awvalid=1 -> all outputs at reset values asynchronously, no rsp_valid; next write 0x20000000 = 123456789 completes normally and sets tests_passed.

Source files
------------

// File: rtl/axi4_lite_initiator_if.sv
// Command/response port plus AXI4-lite master bus of the initiator.
// master = initiator side, slave = command source / responder side.
interface axi4_lite_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic        cmd_insn;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        halted;
  logic        mem_axi_awvalid;
  logic        mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid;
  logic        mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid;
  logic        mem_axi_bready;
  logic        mem_axi_arvalid;
  logic        mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid;
  logic        mem_axi_rready;
  logic [31:0] mem_axi_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_insn,
    input  cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_timeout,
    input  rsp_ready,
    output halted,
    output mem_axi_awvalid, mem_axi_awaddr,
    output mem_axi_awprot,
    input  mem_axi_awready,
    output mem_axi_wvalid, mem_axi_wdata,
    output mem_axi_wstrb,
    input  mem_axi_wready,
    input  mem_axi_bvalid,
    output mem_axi_bready,
    output mem_axi_arvalid, mem_axi_araddr,
    output mem_axi_arprot,
    input  mem_axi_arready,
    input  mem_axi_rvalid, mem_axi_rdata,
    output mem_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_insn,
    output cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_timeout,
    output rsp_ready,
    input  halted,
    input  mem_axi_awvalid, mem_axi_awaddr,
    input  mem_axi_awprot,
    output mem_axi_awready,
    input  mem_axi_wvalid, mem_axi_wdata,
    input  mem_axi_wstrb,
    output mem_axi_wready,
    output mem_axi_bvalid,
    input  mem_axi_bready,
    input  mem_axi_arvalid, mem_axi_araddr,
    input  mem_axi_arprot,
    output mem_axi_arready,
    output mem_axi_rvalid, mem_axi_rdata,
    input  mem_axi_rready
  );
endinterface

// File: rtl/axi4_lite_initiator.sv
// Single-outstanding AXI4-lite master with a hung-responder watchdog.
// A watchdog abort answers the command with rsp_timeout and halts.
module axi4_lite_initiator #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned TO_WIDTH = 16
) (
  input logic                   clk,
  input logic                   resetn,
  axi4_lite_initiator_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, AR, R, WR, B, RESP
  } state_e;

  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST =
    TO_WIDTH'(TIMEOUT - 1);

  state_e              state_q;
  logic [TO_WIDTH-1:0] cnt_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic                halted_q;
  logic                arvalid_q;
  logic [31:0]         araddr_q;
  logic [2:0]          arprot_q;
  logic                rready_q;
  logic                awvalid_q;
  logic [31:0]         awaddr_q;
  logic [2:0]          awprot_q;
  logic                wvalid_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic                bready_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_timeout_q;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic aw_all, w_all, busy, prog, wd_fire;

  assign ar_hs  = arvalid_q & bus.mem_axi_arready;
  assign r_hs   = rready_q  & bus.mem_axi_rvalid;
  assign aw_hs  = awvalid_q & bus.mem_axi_awready;
  assign w_hs   = wvalid_q  & bus.mem_axi_wready;
  assign b_hs   = bready_q  & bus.mem_axi_bvalid;
  assign aw_all = aw_done_q | aw_hs;
  assign w_all  = w_done_q  | w_hs;
  assign busy   = (state_q == AR) || (state_q == R)
               || (state_q == WR) || (state_q == B);
  assign prog   = ar_hs | r_hs | aw_hs | w_hs | b_hs;
  // Fires on the edge that ends the TIMEOUT-th waiting cycle.
  assign wd_fire = WD_EN && (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      halted_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      araddr_q      <= '0;
      arprot_q      <= '0;
      rready_q      <= 1'b0;
      awvalid_q     <= 1'b0;
      awaddr_q      <= '0;
      awprot_q      <= '0;
      wvalid_q      <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      bready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.cmd_valid && !halted_q) begin
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
            if (bus.cmd_write) begin
              state_q   <= WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              awaddr_q  <= bus.cmd_addr;
              awprot_q  <= 3'b000;
              wdata_q   <= bus.cmd_wdata;
              wstrb_q   <= bus.cmd_wstrb;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
            end else begin
              state_q   <= AR;
              arvalid_q <= 1'b1;
              araddr_q  <= bus.cmd_addr;
              arprot_q  <= {bus.cmd_insn, 2'b00};
            end
          end
        end
        AR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= R;
          end
        end
        R: begin
          if (r_hs) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= bus.mem_axi_rdata;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        WR: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_all && w_all) begin
            bready_q <= 1'b1;
            state_q  <= B;
          end
        end
        B: begin
          if (b_hs) begin
            bready_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Every exit from a busy state needs a handshake.
      if (busy) begin
        if (prog) begin
          cnt_q <= '0;
        end else if (wd_fire) begin
          cnt_q         <= '0;
          arvalid_q     <= 1'b0;
          rready_q      <= 1'b0;
          awvalid_q     <= 1'b0;
          wvalid_q      <= 1'b0;
          bready_q      <= 1'b0;
          rsp_valid_q   <= 1'b1;
          rsp_rdata_q   <= '0;
          rsp_timeout_q <= 1'b1;
          halted_q      <= 1'b1;
          state_q       <= RESP;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.cmd_ready       = (state_q == IDLE)
                             && !halted_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_rdata       = rsp_rdata_q;
  assign bus.rsp_timeout     = rsp_timeout_q;
  assign bus.halted          = halted_q;
  assign bus.mem_axi_arvalid = arvalid_q;
  assign bus.mem_axi_araddr  = araddr_q;
  assign bus.mem_axi_arprot  = arprot_q;
  assign bus.mem_axi_rready  = rready_q;
  assign bus.mem_axi_awvalid = awvalid_q;
  assign bus.mem_axi_awaddr  = awaddr_q;
  assign bus.mem_axi_awprot  = awprot_q;
  assign bus.mem_axi_wvalid  = wvalid_q;
  assign bus.mem_axi_wdata   = wdata_q;
  assign bus.mem_axi_wstrb   = wstrb_q;
  assign bus.mem_axi_bready  = bready_q;
endmodule
